// File: rtl/ysyx_22050133_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050133_ifu
// Brief    : Instruction fetch stage. One outstanding 64-bit fetch at a time,
//            {pc, inst} handed to decode, wrong-path fetches discarded.
// Revision : 1.0
// ============================================================================
module ysyx_22050133_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [63:0]      redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [63:0]      imem_addr,
  input  logic             imem_resp_valid,
  input  logic [63:0]      imem_resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [63:0]      c_PC_STEP = 64'd4;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [63:0]      r_pc;
  logic [31:0]      r_inst;
  logic [CNT_W-1:0] r_cnt;

  logic [63:0]      w_redir_pc;
  logic [31:0]      w_sel_inst;
  logic             w_latch;
  logic             w_deliver;

  assign w_redir_pc = redirect_pc & ~64'd3;
  assign w_sel_inst = r_pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
  // A redirect landing with the response means the data is wrong-path: never latch it.
  assign w_latch    = (r_state == S_WAIT) & imem_resp_valid & ~redirect_valid;
  assign w_deliver  = (r_state == S_OUT) & ~redirect_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ: begin
        if (!redirect_valid && imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          w_state_nxt = redirect_valid ? S_REQ : S_OUT;
        end else if (redirect_valid) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_resp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      S_OUT: begin
        if (redirect_valid || out_ready) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    out_valid      = 1'b0;
    imem_addr      = '0;
    out_pc         = '0;
    out_inst       = '0;
    fetch_cnt      = '0;
    if (!rst) begin
      imem_req_valid = (r_state == S_REQ) & ~redirect_valid;
      out_valid      = (r_state == S_OUT) & ~redirect_valid;
      imem_addr      = {r_pc[63:3], 3'b000};
      out_pc         = r_pc;
      out_inst       = r_inst;
      fetch_cnt      = r_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_inst <= '0;
      r_cnt  <= '0;
    end else begin
      if (redirect_valid) begin
        r_pc <= w_redir_pc;
      end else if (w_deliver) begin
        r_pc  <= r_pc + c_PC_STEP;
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      if (w_latch) begin
        r_inst <= w_sel_inst;
      end
    end
  end

endmodule
`default_nettype wire
